matrix_operand_loader: RTL and testbench

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

---
 rtl/matrix_operand_loader.sv | 125 ++++++++++++
 tb/tb_matrix_operand_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_loader.sv
// Buffers one row-major matrix operand (up to MAX_DIM x MAX_DIM) and presents it
// to a downstream operator through a combinational read port until consumed.
module matrix_operand_loader #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned MAX_DIM = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [2:0]        cfg_rows,
    input  logic [2:0]        cfg_cols,
    output logic              cfg_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mat_valid,
    output logic [2:0]        mat_rows,
    output logic [2:0]        mat_cols,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              mat_consume,
    output logic              cfg_error
);

    localparam int unsigned DEPTH     = MAX_DIM * MAX_DIM;
    localparam logic [4:0]  DEPTH_5   = 5'(DEPTH);
    localparam logic [2:0]  MAX_DIM_3 = 3'(MAX_DIM);

    typedef enum logic [1:0] {StIdle, StLoad, StFull} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_rows;
    logic [2:0]        r_cols;
    logic [4:0]        r_count;
    logic [4:0]        r_index;
    logic [DATA_W-1:0] r_buf [DEPTH];
    logic              r_cfg_error;

    logic              w_cfg_ok;
    logic              w_accept_cfg;
    logic              w_reject_cfg;
    logic              w_accept_elem;
    logic              w_last_elem;
    logic [4:0]        w_count_new;

    assign w_cfg_ok = (cfg_rows != 3'd0) && (cfg_rows <= MAX_DIM_3) &&
                      (cfg_cols != 3'd0) && (cfg_cols <= MAX_DIM_3);
    assign w_count_new = {2'b00, cfg_rows} * {2'b00, cfg_cols};
    assign w_last_elem = (r_index == r_count - 5'd1);

    always_comb begin
        w_state_next  = r_state;
        w_accept_cfg  = 1'b0;
        w_reject_cfg  = 1'b0;
        w_accept_elem = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cfg_valid) begin
                    if (w_cfg_ok) begin
                        w_accept_cfg = 1'b1;
                        w_state_next = StLoad;
                    end else begin
                        w_reject_cfg = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    w_accept_elem = 1'b1;
                    if (w_last_elem) w_state_next = StFull;
                end
            end
            StFull: begin
                if (mat_consume) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The index holds at count-1 on the final accept so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows      <= 3'd0;
            r_cols      <= 3'd0;
            r_count     <= 5'd0;
            r_index     <= 5'd0;
            r_cfg_error <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) r_buf[i] <= '0;
        end else begin
            r_cfg_error <= w_reject_cfg;
            if (w_accept_cfg) begin
                r_rows  <= cfg_rows;
                r_cols  <= cfg_cols;
                r_count <= w_count_new;
                r_index <= 5'd0;
                for (int i = 0; i < int'(DEPTH); i++) r_buf[i] <= '0;
            end else if (w_accept_elem) begin
                r_buf[r_index] <= in_data;
                if (!w_last_elem) r_index <= r_index + 5'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if ((rd_addr < r_count) && (rd_addr < DEPTH_5)) rd_data = r_buf[rd_addr];
    end

    assign cfg_ready = (r_state == StIdle);
    assign in_ready  = (r_state == StLoad);
    assign mat_valid = (r_state == StFull);
    assign mat_rows  = r_rows;
    assign mat_cols  = r_cols;
    assign cfg_error = r_cfg_error;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader: directed vector table, corner
// sequences and randomized traffic compared against a queue-based reference.
module tb_matrix_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [2:0] cfg_rows;
    logic [2:0] cfg_cols;
    logic       cfg_ready;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       mat_valid;
    logic [2:0] mat_rows;
    logic [2:0] mat_cols;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic       mat_consume;
    logic       cfg_error;

    matrix_operand_loader #(.DATA_W(4), .MAX_DIM(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_rows    (cfg_rows),
        .cfg_cols    (cfg_cols),
        .cfg_ready   (cfg_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mat_valid   (mat_valid),
        .mat_rows    (mat_rows),
        .mat_cols    (mat_cols),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .mat_consume (mat_consume),
        .cfg_error   (cfg_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: accepted elements kept in arrival order; phase flags.
    int m_rows, m_cols, m_n;
    bit m_load, m_full, m_err;
    int m_q[$];

    typedef struct {
        bit cv; int r; int c; bit iv; int d; bit cons; int addr;
        bit e_cr; bit e_ir; bit e_mv; int e_rows; int e_cols; bit e_err; int e_rd;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_rows = 0; m_cols = 0; m_n = 0;
        m_load = 0; m_full = 0; m_err = 0;
        m_q.delete();
    endtask

    function automatic int exp_rd(input int a);
        if (a < m_n && a < 25 && a < m_q.size()) return m_q[a];
        return 0;
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_err = 0;
            if (m_full) begin
                if (mat_consume) m_full = 0;
            end else if (m_load) begin
                if (in_valid) begin
                    m_q.push_back(int'(in_data));
                    if (m_q.size() == m_n) begin
                        m_load = 0;
                        m_full = 1;
                    end
                end
            end else if (cfg_valid) begin
                if (cfg_rows >= 1 && cfg_rows <= 5 && cfg_cols >= 1 && cfg_cols <= 5) begin
                    m_rows = int'(cfg_rows);
                    m_cols = int'(cfg_cols);
                    m_n    = m_rows * m_cols;
                    m_q.delete();
                    m_load = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("cfg_ready", int'(cfg_ready), int'(!m_load && !m_full));
        chk("in_ready",  int'(in_ready),  int'(m_load));
        chk("mat_valid", int'(mat_valid), int'(m_full));
        chk("mat_rows",  int'(mat_rows),  m_rows);
        chk("mat_cols",  int'(mat_cols),  m_cols);
        chk("cfg_error", int'(cfg_error), int'(m_err));
        chk("rd_data",   int'(rd_data),   exp_rd(int'(rd_addr)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic clr();
        cfg_valid = 0; cfg_rows = 0; cfg_cols = 0;
        in_valid = 0; in_data = 0; mat_consume = 0; rd_addr = 0;
    endtask

    task automatic load_cfg(input int r, input int c);
        cfg_valid = 1; cfg_rows = 3'(r); cfg_cols = 3'(c);
        tick();
        cfg_valid = 0;
    endtask

    task automatic push(input int d);
        in_valid = 1; in_data = 4'(d);
        tick();
        in_valid = 0;
    endtask

    initial begin
        int last;
        // 2x3 load, reads past count, consume, then two rejected descriptors.
        tbl[0]  = '{1, 2, 3, 0, 0, 0, 0,  0, 1, 0, 2, 3, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 1, 0, 0,  0, 1, 0, 2, 3, 0, 1};
        tbl[2]  = '{0, 0, 0, 1, 2, 0, 1,  0, 1, 0, 2, 3, 0, 2};
        tbl[3]  = '{0, 0, 0, 1, 3, 0, 2,  0, 1, 0, 2, 3, 0, 3};
        tbl[4]  = '{0, 0, 0, 1, 4, 0, 3,  0, 1, 0, 2, 3, 0, 4};
        tbl[5]  = '{0, 0, 0, 1, 5, 0, 4,  0, 1, 0, 2, 3, 0, 5};
        tbl[6]  = '{0, 0, 0, 1, 6, 0, 5,  0, 0, 1, 2, 3, 0, 6};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 6,  0, 0, 1, 2, 3, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 4,  0, 0, 1, 2, 3, 0, 5};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 4,  1, 0, 0, 2, 3, 0, 5};
        tbl[10] = '{1, 0, 3, 0, 0, 0, 0,  1, 0, 0, 2, 3, 1, 1};
        tbl[11] = '{1, 6, 2, 0, 0, 0, 0,  1, 0, 0, 2, 3, 1, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 3, 0, 1};

        clr();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_mat_valid", int'(mat_valid), 0);
        chk("rst_mat_rows",  int'(mat_rows), 0);

        for (int i = 0; i < 13; i++) begin
            cfg_valid = tbl[i].cv; cfg_rows = 3'(tbl[i].r); cfg_cols = 3'(tbl[i].c);
            in_valid = tbl[i].iv; in_data = 4'(tbl[i].d);
            mat_consume = tbl[i].cons; rd_addr = 5'(tbl[i].addr);
            tick();
            chk($sformatf("v%0d_cfg_ready", i), int'(cfg_ready), int'(tbl[i].e_cr));
            chk($sformatf("v%0d_in_ready", i),  int'(in_ready),  int'(tbl[i].e_ir));
            chk($sformatf("v%0d_mat_valid", i), int'(mat_valid), int'(tbl[i].e_mv));
            chk($sformatf("v%0d_mat_rows", i),  int'(mat_rows),  tbl[i].e_rows);
            chk($sformatf("v%0d_mat_cols", i),  int'(mat_cols),  tbl[i].e_cols);
            chk($sformatf("v%0d_cfg_error", i), int'(cfg_error), int'(tbl[i].e_err));
            chk($sformatf("v%0d_rd_data", i),   int'(rd_data),   tbl[i].e_rd);
        end
        clr();

        // 5x5 with a bubble after every element.
        load_cfg(5, 5);
        last = 0;
        for (int k = 0; k < 25; k++) begin
            last = int'($urandom_range(0, 15));
            if (k == 24) chk("full_before_25th", int'(mat_valid), 0);
            push(last);
            tick();
        end
        rd_addr = 5'd24;
        #1;
        chk("full_after_25", int'(mat_valid), 1);
        chk("rd_last_25", int'(rd_data), last);

        // Traffic while FULL must be ignored.
        in_valid = 1; in_data = 4'hF; cfg_valid = 1; cfg_rows = 3'd1; cfg_cols = 3'd1;
        tick();
        chk("full_frozen_rows", int'(mat_rows), 5);
        chk("full_frozen_cols", int'(mat_cols), 5);
        chk("full_frozen_rd", int'(rd_data), last);
        clr();
        mat_consume = 1;
        tick();
        mat_consume = 0;
        chk("consume_idle", int'(cfg_ready), 1);

        // Reset in the middle of a load.
        load_cfg(3, 3);
        for (int k = 0; k < 4; k++) push(k + 1);
        rst = 1;
        #1;
        model_reset();
        chk("async_rst_in_ready", int'(in_ready), 0);
        chk("async_rst_cfg_ready", int'(cfg_ready), 1);
        chk("async_rst_rows", int'(mat_rows), 0);
        tick();
        rst = 0;
        load_cfg(1, 1);
        push(7);
        rd_addr = 5'd0;
        #1;
        chk("post_rst_valid", int'(mat_valid), 1);
        chk("post_rst_rd0", int'(rd_data), 7);
        mat_consume = 1;
        tick();
        mat_consume = 0;

        // 1x1, consumed in the very first FULL cycle.
        load_cfg(1, 1);
        push(9);
        chk("one_elem_full", int'(mat_valid), 1);
        mat_consume = 1;
        tick();
        mat_consume = 0;
        chk("one_elem_idle", int'(cfg_ready), 1);
        chk("one_elem_valid_low", int'(mat_valid), 0);

        // Randomized traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 149) == 0);
            cfg_valid   = 1'($urandom_range(0, 1));
            cfg_rows    = 3'($urandom_range(0, 7));
            cfg_cols    = 3'($urandom_range(0, 7));
            in_valid    = 1'($urandom_range(0, 1));
            in_data     = 4'($urandom_range(0, 15));
            mat_consume = ($urandom_range(0, 3) == 0);
            rd_addr     = 5'($urandom_range(0, 31));
            tick();
        end
        rst = 0;
        clr();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
